// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared types for the LED breathing engine: ramp-law selector, direction
// encoding and the mode-input decode used by the top level.
// ----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        MODE_TRI = 2'd0,
        MODE_SAW = 2'd1,
        MODE_FIX = 2'd2
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Raw encoding 3 is an alias for the fixed-level law.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd0:    m = MODE_TRI;
            2'd1:    m = MODE_SAW;
            default: m = MODE_FIX;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/breathe_channel.sv
// ----------------------------------------------------------------------------
// breathe_channel
// One LED channel: duty/direction registers, ramp law and PWM compare flop.
// Ports:
//   clk, resetn     clock, async active-low reset
//   enable          1 = run; 0 = blank the LED (duty/dir hold)
//   boundary        last enabled count of the PWM period (duty may change)
//   tick            a ramp tick is due at this boundary
//   mode_q          ramp law to apply at the boundary
//   step            per-channel step size
//   pwm_cnt         shared PWM counter
//   led             registered PWM output
// ----------------------------------------------------------------------------
module breathe_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = 11,
    parameter int STEP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 boundary,
    input  logic                 tick,
    input  mode_e                mode_q,
    input  logic [STEP_BITS-1:0] step,
    input  logic [PWM_BITS-1:0]  pwm_cnt,
    output logic                 led
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS:0]   DUTY_MAX_EXT = {1'b0, DUTY_MAX};

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                led_q;
    logic [PWM_BITS:0]   step_ext_s;
    logic [PWM_BITS:0]   sum_s;
    logic [PWM_BITS-1:0] fix_s;

    // Ramp law: duty/dir only move on a period boundary so the PWM pattern
    // of a running period is never disturbed.
    always_comb begin
        step_ext_s = {{(PWM_BITS + 1 - STEP_BITS){1'b0}}, step};
        sum_s      = {1'b0, duty_q} + step_ext_s;
        fix_s      = PWM_BITS'(step) << (PWM_BITS - STEP_BITS);
        duty_d     = duty_q;
        dir_d      = dir_q;
        if (boundary) begin
            case (mode_q)
                MODE_TRI: begin
                    if (tick) begin
                        if (dir_q == DIR_UP) begin
                            if (sum_s >= DUTY_MAX_EXT) begin
                                duty_d = DUTY_MAX;
                                dir_d  = DIR_DOWN;
                            end else begin
                                duty_d = sum_s[PWM_BITS-1:0];
                            end
                        end else begin
                            if ({1'b0, duty_q} <= step_ext_s) begin
                                duty_d = '0;
                                dir_d  = DIR_UP;
                            end else begin
                                // step < duty here, so the truncation is exact
                                duty_d = duty_q - step_ext_s[PWM_BITS-1:0];
                            end
                        end
                    end else begin
                        duty_d = duty_q;
                    end
                end
                MODE_SAW: begin
                    dir_d = DIR_UP;
                    if (tick) begin
                        duty_d = sum_s[PWM_BITS-1:0];
                    end else begin
                        duty_d = duty_q;
                    end
                end
                default: begin
                    // fixed level reloads every boundary, tick or not
                    duty_d = fix_s;
                    dir_d  = DIR_UP;
                end
            endcase
        end else begin
            duty_d = duty_q;
            dir_d  = dir_q;
        end
    end

    // Channel state and registered PWM compare (old duty is used on the
    // boundary cycle; cnt==MAX never lights the LED so nothing is lost).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duty_q <= '0;
            dir_q  <= DIR_UP;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            dir_q  <= dir_d;
            led_q  <= enable && (pwm_cnt < duty_q);
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_breathe_pwm.sv
// ----------------------------------------------------------------------------
// led_breathe_pwm
// Multi-channel LED breathing engine with a shared free-running PWM counter,
// a ramp prescaler and per-channel triangle / sawtooth / fixed duty laws.
// resetn must be released synchronously to clk by the board reset logic.
// Ports:
//   clk          system clock
//   resetn       async active-low reset
//   enable       1 = run, 0 = freeze state and blank LEDs
//   mode         0 triangle, 1 sawtooth, 2/3 fixed level
//   step         channel i step at [i*STEP_BITS +: STEP_BITS]
//   led          registered active-high PWM outputs
//   period_done  one-cycle pulse aligned with the last count of a period
// ----------------------------------------------------------------------------
module led_breathe_pwm
    import led_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int PWM_BITS  = 11,
    parameter int STEP_BITS = 8,
    parameter int RAMP_DIV  = 1024
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic [NUM_CH*STEP_BITS-1:0]   step,
    output logic [NUM_CH-1:0]             led,
    output logic                          period_done
);

    localparam int PRESC_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(RAMP_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick_pend_q, tick_pend_d;
    mode_e               mode_q, mode_d;
    logic                period_done_q;
    logic                boundary_s;
    logic                tick_set_s;
    logic                tick_s;
    mode_e               mode_in_s;
    mode_e               law_mode_s;

    // Counter, prescaler and tick bookkeeping; everything holds while disabled.
    always_comb begin
        boundary_s = enable && (pwm_cnt_q == CNT_MAX);
        tick_set_s = enable && (presc_q == PRESC_LAST);
        // ticks seen since the last boundary, including this cycle's
        tick_s     = tick_pend_q | tick_set_s;
        mode_in_s  = decode_mode(mode);
        // the law taken at a boundary is the mode sampled on that boundary
        law_mode_s = boundary_s ? mode_in_s : mode_q;
        pwm_cnt_d  = pwm_cnt_q;
        presc_d    = presc_q;
        if (enable) begin
            pwm_cnt_d = pwm_cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pwm_cnt_d = pwm_cnt_q;
            presc_d   = presc_q;
        end
        if (boundary_s) begin
            tick_pend_d = 1'b0;
            mode_d      = mode_in_s;
        end else begin
            tick_pend_d = tick_s;
            mode_d      = mode_q;
        end
    end

    // Shared state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt_q     <= '0;
            presc_q       <= '0;
            tick_pend_q   <= 1'b0;
            mode_q        <= MODE_TRI;
            period_done_q <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            presc_q       <= presc_d;
            tick_pend_q   <= tick_pend_d;
            mode_q        <= mode_d;
            period_done_q <= boundary_s;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        breathe_channel #(
            .PWM_BITS  (PWM_BITS),
            .STEP_BITS (STEP_BITS)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .enable   (enable),
            .boundary (boundary_s),
            .tick     (tick_s),
            .mode_q   (law_mode_s),
            .step     (step[i*STEP_BITS +: STEP_BITS]),
            .pwm_cnt  (pwm_cnt_q),
            .led      (led[i])
        );
    end

    assign period_done = period_done_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// ----------------------------------------------------------------------------
// tb_led_breathe_pwm
// Scoreboard bench: the stimulus process drives inputs on the falling edge
// and pushes the expected registered outputs computed by a reference model
// that works from the enabled-cycle count; a monitor pops one entry per
// rising edge and compares.
// ----------------------------------------------------------------------------
module tb_led_breathe_pwm;

    localparam int NCH = 2;
    localparam int PB  = 4;
    localparam int SB  = 4;
    localparam int RD  = 4;
    localparam int PER = 16;
    localparam int MAXV = 15;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            enable = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [NCH*SB-1:0] step = '0;
    logic [NCH-1:0]  led;
    logic            period_done;

    led_breathe_pwm #(
        .NUM_CH(NCH), .PWM_BITS(PB), .STEP_BITS(SB), .RAMP_DIV(RD)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
        .step(step), .led(led), .period_done(period_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] led;
        logic           pd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int   en_cycles = 0;      // enabled cycles since reset
    int   last_bnd  = -1;     // enabled-cycle index of the previous boundary
    int   duty [NCH];
    bit   going_down [NCH];

    function automatic void model_reset();
        en_cycles = 0;
        last_bnd  = -1;
        for (int c = 0; c < NCH; c++) begin
            duty[c] = 0;
            going_down[c] = 1'b0;
        end
    endfunction

    // Apply one boundary: a step happens when at least one prescaler wrap
    // (enabled index j with j % RD == RD-1) fell in (last_bnd, k].
    function automatic void model_boundary(input int k, input logic [1:0] md,
                                           input logic [NCH*SB-1:0] st);
        int  ticks;
        int  s;
        ticks = (k + 1) / RD - (last_bnd + 1) / RD;
        last_bnd = k;
        for (int c = 0; c < NCH; c++) begin
            s = int'((st >> (c * SB)) & 8'h0F);
            if (md == 2'd0) begin
                if (ticks > 0) begin
                    if (!going_down[c]) begin
                        if (duty[c] + s >= MAXV) begin
                            duty[c] = MAXV; going_down[c] = 1'b1;
                        end else duty[c] = duty[c] + s;
                    end else begin
                        if (duty[c] <= s) begin
                            duty[c] = 0; going_down[c] = 1'b0;
                        end else duty[c] = duty[c] - s;
                    end
                end
            end else if (md == 2'd1) begin
                going_down[c] = 1'b0;
                if (ticks > 0) duty[c] = (duty[c] + s) % PER;
            end else begin
                going_down[c] = 1'b0;
                duty[c] = s * (1 << (PB - SB));
            end
        end
    endfunction

    // One clock of stimulus plus the expected outputs after the next edge.
    task automatic cyc(input logic rn, input logic en, input logic [1:0] md,
                       input logic [NCH*SB-1:0] st);
        exp_t e;
        int   c;
        @(negedge clk);
        resetn = rn; enable = en; mode = md; step = st;
        if (!rn) begin
            model_reset();
            e.led = '0; e.pd = 1'b0;
        end else begin
            c = en_cycles % PER;
            for (int ch = 0; ch < NCH; ch++) e.led[ch] = en && (c < duty[ch]);
            e.pd = en && (c == PER - 1);
            if (en) begin
                if (c == PER - 1) model_boundary(en_cycles, md, st);
                en_cycles++;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic en, input logic [1:0] md,
                       input logic [NCH*SB-1:0] st);
        for (int i = 0; i < n; i++) cyc(1'b1, en, md, st);
    endtask

    // Asynchronous reset assertion away from any clock edge.
    task automatic async_reset_check();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (led !== '0) begin
            errors++;
            $display("FAIL async_reset_led got=%b want=00", led);
        end
        checks++;
        if (period_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_pd got=%b want=0", period_done);
        end
        cyc(1'b0, 1'b1, 2'd0, '0);
        cyc(1'b0, 1'b1, 2'd0, '0);
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (led !== e.led) begin
                errors++;
                $display("FAIL led t=%0t got=%b want=%b", $time, led, e.led);
            end
            checks++;
            if (period_done !== e.pd) begin
                errors++;
                $display("FAIL period_done t=%0t got=%b want=%b", $time, period_done, e.pd);
            end
        end
    end

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'd0, '0);
        // first period_done on the 16th counting cycle
        run(20, 1'b1, 2'd0, 8'h00);
        async_reset_check();
        // triangle on ch0, step 5
        run(8 * PER, 1'b1, 2'd0, 8'h05);
        // sawtooth on ch1, step 6
        run(5 * PER, 1'b1, 2'd1, 8'h60);
        // fixed level 0xA on both channels
        run(3 * PER, 1'b1, 2'd2, 8'hAA);
        // freeze mid-period for 37 cycles, then resume
        run(21, 1'b1, 2'd0, 8'h33);
        run(37, 1'b0, 2'd0, 8'h33);
        run(40, 1'b1, 2'd0, 8'h33);
        // step = 0 holds duty, mode change mid-period
        run(2 * PER, 1'b1, 2'd1, 8'h00);
        run(7, 1'b1, 2'd0, 8'h27);
        run(30, 1'b1, 2'd3, 8'h27);
        // mode 3 alias and reset in the middle of a running period
        run(9, 1'b1, 2'd1, 8'h3C);
        async_reset_check();
        // randomized segments
        for (int seg = 0; seg < 120; seg++) begin
            logic        en;
            logic [1:0]  md;
            logic [7:0]  st;
            en = ($urandom_range(0, 7) != 0);
            md = 2'($urandom_range(0, 3));
            st = 8'($urandom_range(0, 255));
            run($urandom_range(1, 30), en, md, st);
            if (seg == 60) async_reset_check();
        end
        // let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
